fft8_ctrl: RTL and testbench

Sequencing controller for the combinational 8-point FFT datapath (`fft8`). It accepts 8 complex Q24.8 samples serially over a valid/ready stream and drives all 16 `fft8` inputs in parallel from a sample register bank. After a programmable settle time it captures the 16 `fft8` outputs and returns the 8 bins serially over a second valid/ready stream. It sits between the sample source and result sink, and turns the flat combinational FFT into a framed, back-pressurable stream block.

---
 rtl/fft8_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fft8_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_ctrl.sv
// fft8_ctrl: framing controller for the combinational 8-point FFT datapath.
// Samples stream in over s_*, go into an 8-entry bank that drives fft8 in
// parallel, are captured after SETTLE_CYC cycles, and stream out over m_*.
// Optional build macro: FFT8_CTRL_SCALE_EN (arithmetic >>>3 on captured words).
module fft8_ctrl #(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [DATA_W-1:0]   s_real,
  input  logic signed [DATA_W-1:0]   s_imag,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [DATA_W-1:0]   m_real,
  output logic signed [DATA_W-1:0]   m_imag,
  output logic [2:0]                 m_index,
  output logic                       frame_done,
  output logic [8*DATA_W-1:0]        fft_in_re,
  output logic [8*DATA_W-1:0]        fft_in_im,
  input  logic [8*DATA_W-1:0]        fft_out_re,
  input  logic [8*DATA_W-1:0]        fft_out_im
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_UNLOAD = 2'd2;

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC);

  logic [1:0] state_q, state_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       s_ready_q, s_ready_d;
  logic       m_valid_q, m_valid_d;
  logic       frame_done_q, frame_done_d;

  logic signed [DATA_W-1:0] bank_re_q [8];
  logic signed [DATA_W-1:0] bank_im_q [8];
  logic signed [DATA_W-1:0] bank_re_d [8];
  logic signed [DATA_W-1:0] bank_im_d [8];
  logic signed [DATA_W-1:0] res_re_q  [8];
  logic signed [DATA_W-1:0] res_im_q  [8];
  logic signed [DATA_W-1:0] res_re_d  [8];
  logic signed [DATA_W-1:0] res_im_d  [8];

  logic s_acc;
  logic m_acc;

  // Capture-time scaling; width is preserved, shift floors toward -inf.
  function automatic logic signed [DATA_W-1:0] scale_word(
    input logic signed [DATA_W-1:0] w
  );
`ifdef FFT8_CTRL_SCALE_EN
    return w >>> 3;
`else
    return w;
`endif
  endfunction

  // Next-state logic: LOAD fills the bank, SETTLE waits then captures, UNLOAD drains.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    settle_cnt_d = settle_cnt_q;
    frame_done_d = 1'b0;
    bank_re_d    = bank_re_q;
    bank_im_d    = bank_im_q;
    res_re_d     = res_re_q;
    res_im_d     = res_im_q;
    s_acc        = s_valid & s_ready_q;
    m_acc        = m_valid_q & m_ready;

    case (state_q)
      ST_LOAD: begin
        if (s_acc) begin
          bank_re_d[wr_ptr_q] = s_real;
          bank_im_d[wr_ptr_q] = s_imag;
          wr_ptr_d            = wr_ptr_q + 3'd1;
          if (wr_ptr_q == 3'd7) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = 4'd0;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LIM) begin
          for (int k = 0; k < 8; k++) begin
            res_re_d[k] = scale_word($signed(fft_out_re[DATA_W*k +: DATA_W]));
            res_im_d[k] = scale_word($signed(fft_out_im[DATA_W*k +: DATA_W]));
          end
          settle_cnt_d = 4'd0;
          state_d      = ST_UNLOAD;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_UNLOAD: begin
        if (m_acc) begin
          rd_ptr_d = rd_ptr_q + 3'd1;
          if (rd_ptr_q == 3'd7) begin
            frame_done_d = 1'b1;
            state_d      = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
    m_valid_d = (state_d == ST_UNLOAD);
  end

  // Control registers; s_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= 3'd0;
      rd_ptr_q     <= 3'd0;
      settle_cnt_q <= 4'd0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      settle_cnt_q <= settle_cnt_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sample bank and result buffer; cleared by reset so fft_in_*/m_* read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        bank_re_q[k] <= '0;
        bank_im_q[k] <= '0;
        res_re_q[k]  <= '0;
        res_im_q[k]  <= '0;
      end
    end else begin
      bank_re_q <= bank_re_d;
      bank_im_q <= bank_im_d;
      res_re_q  <= res_re_d;
      res_im_q  <= res_im_d;
    end
  end

  // Flatten the bank onto the fft8 input buses, sample k at [DATA_W*k +: DATA_W].
  always_comb begin
    fft_in_re = '0;
    fft_in_im = '0;
    for (int k = 0; k < 8; k++) begin
      fft_in_re[DATA_W*k +: DATA_W] = bank_re_q[k];
      fft_in_im[DATA_W*k +: DATA_W] = bank_im_q[k];
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_index    = rd_ptr_q;
  assign m_real     = res_re_q[rd_ptr_q];
  assign m_imag     = res_im_q[rd_ptr_q];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft8_ctrl.sv
// tb_fft8_ctrl: scoreboard bench for fft8_ctrl with a behavioural fft8 stand-in.
// Honours FFT8_CTRL_SCALE_EN when the build defines it.
module tb_fft8_ctrl;
  localparam int DW = 32;
  localparam int SC = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 m_ready = 1'b1;
  logic signed [DW-1:0] s_real = '0;
  logic signed [DW-1:0] s_imag = '0;
  logic                 s_ready;
  logic                 m_valid;
  logic signed [DW-1:0] m_real;
  logic signed [DW-1:0] m_imag;
  logic [2:0]           m_index;
  logic                 frame_done;
  logic [8*DW-1:0]      fft_in_re;
  logic [8*DW-1:0]      fft_in_im;
  logic [8*DW-1:0]      fft_out_re;
  logic [8*DW-1:0]      fft_out_im;

  fft8_ctrl #(.DATA_W(DW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .frame_done(frame_done),
    .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
    .fft_out_re(fft_out_re), .fft_out_im(fft_out_im)
  );

  always #5 clk = ~clk;

  // Stand-in fft8: DFT with cos table scaled by 2^14 (cos45 ~ 11585).
  function automatic longint ctab(input int n);
    case (n)
      0: return 16384;
      1: return 11585;
      2: return 0;
      3: return -11585;
      4: return -16384;
      5: return -11585;
      6: return 0;
      default: return 11585;
    endcase
  endfunction

  function automatic longint dft(input logic [8*DW-1:0] xr, input logic [8*DW-1:0] xi,
                                 input int m, input bit want_im);
    longint acc = 0;
    for (int k = 0; k < 8; k++) begin
      int     n = (m * k) % 8;
      longint c = ctab(n);
      longint s = ctab((n + 6) % 8);
      longint a = longint'($signed(xr[DW*k +: DW]));
      longint b = longint'($signed(xi[DW*k +: DW]));
      if (want_im) acc += b * c - a * s;
      else         acc += a * c + b * s;
    end
    return acc >>> 14;
  endfunction

  always_comb begin
    fft_out_re = '0;
    fft_out_im = '0;
    for (int m = 0; m < 8; m++) begin
      fft_out_re[DW*m +: DW] = DW'(dft(fft_in_re, fft_in_im, m, 1'b0));
      fft_out_im[DW*m +: DW] = DW'(dft(fft_in_re, fft_in_im, m, 1'b1));
    end
  end

  function automatic longint sc(input longint v);
`ifdef FFT8_CTRL_SCALE_EN
    return v >>> 3;
`else
    return v;
`endif
  endfunction

  typedef struct {
    logic [2:0] idx;
    longint     re;
    longint     im;
    bit         chk;
  } exp_t;

  exp_t   sb_q[$];
  int     nchecks = 0;
  int     nfail = 0;
  int     hs_cnt = 0;
  bit     fd_exp = 1'b0;
  logic signed [DW-1:0] fr_re [8];
  logic signed [DW-1:0] fr_im [8];

  function automatic void check(input string name, input longint act, input longint exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_bin(input int idx, input longint re, input longint im, input bit chk);
    exp_t e;
    e.idx = 3'(idx);
    e.re  = sc(re);
    e.im  = sc(im);
    e.chk = chk;
    sb_q.push_back(e);
  endfunction

  // Monitor: pop and compare on every output handshake; track frame_done and input handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      fd_exp = 1'b0;
    end else begin
      check("frame_done", longint'(frame_done), longint'(fd_exp));
      fd_exp = 1'b0;
      if (s_valid && s_ready) hs_cnt++;
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_bin", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("bin_index", longint'(m_index), longint'(e.idx));
          if (e.chk) begin
            check("bin_real", longint'(m_real), e.re);
            check("bin_imag", longint'(m_imag), e.im);
          end
          fd_exp = (e.idx == 3'd7);
        end
      end
    end
  end

  task automatic put_sample(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    bit hs;
    int n;
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    n = 0;
    do begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 50);
    if (!hs) check("s_handshake_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < 8; k++) begin
      put_sample(fr_re[k], fr_im[k]);
      if (gaps && k < 7) begin
        s_real = 32'h0000_0BAD;
        s_imag = 32'h0000_0BAD;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", longint'(sb_q.size()), 0);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_impulse(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
    fr_re[0] = re;
    fr_im[0] = im;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", longint'(s_ready), 0);
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_m_index", longint'(m_index), 0);
    check("rst_frame_done", longint'(frame_done), 0);
    check("rst_m_real", longint'(m_real), 0);
    check("rst_fft_in_zero", longint'(fft_in_re == '0 && fft_in_im == '0), 1);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready_low", longint'(s_ready), 0);
    @(posedge clk);
    #1;
    check("rel_s_ready_high", longint'(s_ready), 1);

    // Impulse with latency check
    set_impulse(256, 0);
    for (int k = 0; k < 8; k++) push_bin(k, 256, 0, 1'b1);
    send_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_m_valid", longint'(m_valid), (i == 2) ? 1 : 0);
      if (i == 0) check("settle_s_ready", longint'(s_ready), 0);
    end
    drain();

    // DC
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 256;
      fr_im[k] = 256;
    end
    push_bin(0, 2048, 2048, 1'b1);
    for (int k = 1; k < 8; k++) push_bin(k, 0, 0, 1'b1);
    send_frame(1'b0);
    drain();

    // Ramp: bin 0 exact, other bins only index-checked; bank checked during SETTLE
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = DW'(k * 256);
      fr_im[k] = DW'(k * 256);
    end
    push_bin(0, 7168, 7168, 1'b1);
    for (int k = 1; k < 8; k++) push_bin(k, 0, 0, 1'b0);
    send_frame(1'b0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("ramp_fft_in_re", longint'($signed(fft_in_re[DW*k +: DW])), longint'(k * 256));
      check("ramp_fft_in_im", longint'($signed(fft_in_im[DW*k +: DW])), longint'(k * 256));
    end
    drain();

    // Backpressure at bin 3
    set_impulse(512, -256);
    for (int k = 0; k < 8; k++) push_bin(k, 512, -256, 1'b1);
    send_frame(1'b0);
    begin
      int n = 0;
      bit found = 1'b0;
      while (!found && n < 50) begin
        @(negedge clk);
        found = m_valid && (m_index == 3'd2);
        n++;
      end
      check("bp_reach_bin2", longint'(found), 1);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid", longint'(m_valid), 1);
      check("bp_m_index", longint'(m_index), 3);
      check("bp_m_real", longint'(m_real), sc(512));
      check("bp_m_imag", longint'(m_imag), sc(-256));
      check("bp_s_ready", longint'(s_ready), 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain();

    // Input gaps plus an extra s_valid during SETTLE
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 256;
      fr_im[k] = 256;
    end
    push_bin(0, 2048, 2048, 1'b1);
    for (int k = 1; k < 8; k++) push_bin(k, 0, 0, 1'b1);
    hs0 = hs_cnt;
    send_frame(1'b1);
    s_valid = 1'b1;
    s_real  = 32'h0000_0BAD;
    s_imag  = 32'h0000_0BAD;
    @(negedge clk);
    check("settle_extra_s_ready", longint'(s_ready), 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    drain();
    check("gap_handshakes", longint'(hs_cnt - hs0), 8);
    for (int k = 0; k < 8; k++)
      check("gap_bank_re", longint'($signed(fft_in_re[DW*k +: DW])), 256);

    // Mid-frame reset after 4 samples
    for (int k = 0; k < 4; k++) put_sample(DW'(1000 + k), DW'(-77));
    rst_n = 1'b0;
    #1;
    check("mrst_s_ready", longint'(s_ready), 0);
    check("mrst_m_valid", longint'(m_valid), 0);
    check("mrst_fft_in_zero", longint'(fft_in_re == '0 && fft_in_im == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_s_ready_back", longint'(s_ready), 1);
    set_impulse(256, 0);
    for (int k = 0; k < 8; k++) push_bin(k, 256, 0, 1'b1);
    send_frame(1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
